// File: rtl/transmissor_16.sv
// 16-bit word transmitter: two UART-style frames (start, 8 data LSB-first, parity, stop), low byte first.
// Optional macro TX16_GAP_EN inserts GAP_BITS idle bit periods between the two frames.
module transmissor_16 #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned PARIDADE_IMPAR = 0,
    parameter int unsigned GAP_BITS       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [15:0] dados,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [2:0]  db_estado
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_W   = (GAP_BITS < 2) ? 1 : $clog2(GAP_BITS);
    localparam int unsigned FRAME_W = 11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
    localparam logic [3:0]       BIT_LAST = 4'd10;
    localparam logic             PAR_ODD  = (PARIDADE_IMPAR != 0);
`ifdef TX16_GAP_EN
    localparam logic GAP_ON = (GAP_BITS != 0);
`else
    localparam logic GAP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        CARREGA_1   = 3'd1,
        TRANSMITE_1 = 3'd2,
        ESPERA      = 3'd3,
        CARREGA_2   = 3'd4,
        TRANSMITE_2 = 3'd5,
        FIM         = 3'd6
    } estado_t;

    estado_t              state_q, state_d;
    logic [15:0]          data_q, data_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 saida_q, saida_d;
    logic                 ocupado_q, ocupado_d;
    logic                 pronto_q, pronto_d;

    // Frame as shifted out from bit 0: start, data LSB-first, parity, stop.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] b);
        return {1'b1, (^b) ^ PAR_ODD, b, 1'b0};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            data_q    <= '0;
            frame_q   <= '0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            saida_q   <= saida_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    // Outputs are computed for the state being entered so they line up with it.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        frame_d   = frame_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        saida_d   = 1'b1;

        case (state_q)
            INICIAL: begin
                if (partida) begin
                    state_d = CARREGA_1;
                    data_d  = dados;
                end
            end
            CARREGA_1, CARREGA_2: begin
                frame_d   = build_frame((state_q == CARREGA_1) ? data_q[7:0] : data_q[15:8]);
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                saida_d   = 1'b0;
                state_d   = (state_q == CARREGA_1) ? TRANSMITE_1 : TRANSMITE_2;
            end
            TRANSMITE_1, TRANSMITE_2: begin
                saida_d = frame_q[0];
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        saida_d   = 1'b1;
                        gap_cnt_d = '0;
                        if (state_q == TRANSMITE_1) begin
                            state_d = GAP_ON ? ESPERA : CARREGA_2;
                        end else begin
                            state_d = FIM;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        frame_d   = {1'b1, frame_q[FRAME_W-1:1]};
                        saida_d   = frame_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ESPERA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = CARREGA_2;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            FIM: begin
                state_d = INICIAL;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        ocupado_d = (state_d != INICIAL);
        pronto_d  = (state_d == FIM);
    end

    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_transmissor_16.sv
// Self-checking bench for transmissor_16: even- and odd-parity instances share stimulus
// and are compared cycle by cycle against a timeline model of the word transmission.
module tb_transmissor_16;

    localparam int C   = 4;
    localparam int GAP = 2;
`ifdef TX16_GAP_EN
    localparam int G = GAP * C;
`else
    localparam int G = 0;
`endif
    localparam int END_CYC = 22 * C + 3 + G;

    logic        clock = 1'b0;
    logic        reset;
    logic        partida;
    logic [15:0] dados;
    logic        ser [2];
    logic        ocu [2];
    logic        prt [2];
    logic [2:0]  st  [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    transmissor_16 #(.CLKS_PER_BIT(C), .PARIDADE_IMPAR(0), .GAP_BITS(GAP)) u_even (
        .clock(clock), .reset(reset), .partida(partida), .dados(dados),
        .saida_serial(ser[0]), .ocupado(ocu[0]), .pronto(prt[0]), .db_estado(st[0])
    );

    transmissor_16 #(.CLKS_PER_BIT(C), .PARIDADE_IMPAR(1), .GAP_BITS(GAP)) u_odd (
        .clock(clock), .reset(reset), .partida(partida), .dados(dados),
        .saida_serial(ser[1]), .ocupado(ocu[1]), .pronto(prt[1]), .db_estado(st[1])
    );

    // Bit idx of a frame: 0 start, 1..8 data LSB-first, 9 parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] b, input bit odd, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    // {state, line} expected in cycle j after the acceptance edge (j = 1 .. END_CYC).
    function automatic logic [3:0] expect_at(input logic [15:0] d, input bit odd, input int j);
        int f2;
        f2 = 11 * C + 3 + G;
        if (j == 1)               return {3'd1, 1'b1};
        if (j < 2 + 11 * C)       return {3'd2, frame_bit(d[7:0], odd, (j - 2) / C)};
        if (j < 2 + 11 * C + G)   return {3'd3, 1'b1};
        if (j == 2 + 11 * C + G)  return {3'd4, 1'b1};
        if (j < f2 + 11 * C)      return {3'd5, frame_bit(d[15:8], odd, (j - f2) / C)};
        return {3'd6, 1'b1};
    endfunction

    // Follows one accepted word; optional busy request, mid-word reset, or held partida.
    task automatic run_word(input logic [15:0] d, input int busy_at, input int reset_at,
                            input bit hold, input logic [15:0] next_d);
        logic [3:0] e;
        for (int j = 1; j <= END_CYC; j++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                e = expect_at(d, k == 1, j);
                checks += 4;
                if (ser[k] !== e[0]) begin
                    errors++;
                    $display("FAIL line inst%0d word %h cycle %0d: got %b expected %b", k, d, j, ser[k], e[0]);
                end
                if (st[k] !== e[3:1]) begin
                    errors++;
                    $display("FAIL state inst%0d word %h cycle %0d: got %0d expected %0d", k, d, j, st[k], e[3:1]);
                end
                if (ocu[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL ocupado inst%0d word %h cycle %0d: got %b expected 1", k, d, j, ocu[k]);
                end
                if (prt[k] !== (j == END_CYC)) begin
                    errors++;
                    $display("FAIL pronto inst%0d word %h cycle %0d: got %b expected %b", k, d, j, prt[k], j == END_CYC);
                end
            end
            if (j == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    checks += 4;
                    if (ser[k] !== 1'b1 || ocu[k] !== 1'b0 || st[k] !== 3'd0 || prt[k] !== 1'b0) begin
                        errors += 4;
                        $display("FAIL reset_mid inst%0d: got line=%b ocupado=%b state=%0d pronto=%b expected 1 0 0 0",
                                 k, ser[k], ocu[k], st[k], prt[k]);
                    end
                end
                return;
            end
            if (j == busy_at) begin
                partida = 1'b1;
                dados   = 16'hFFFF;
            end
            if (j == busy_at + 1 && !hold) partida = 1'b0;
            if (hold && j == END_CYC) dados = next_d;
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (ser[k] !== 1'b1 || ocu[k] !== 1'b0) begin
                errors += 2;
                $display("FAIL idle_after inst%0d word %h: got line=%b ocupado=%b expected 1 0", k, d, ser[k], ocu[k]);
            end
            checks += 2;
            if (st[k] !== 3'd0 || prt[k] !== 1'b0) begin
                errors += 2;
                $display("FAIL idle_state inst%0d word %h: got state=%0d pronto=%b expected 0 0", k, d, st[k], prt[k]);
            end
        end
    endtask

    task automatic start_word(input logic [15:0] d);
        @(posedge clock); #1;
        partida = 1'b1;
        dados   = d;
        @(posedge clock); #1;
        partida = 1'b0;
        dados   = 16'($urandom);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        partida = 1'b1;
        dados   = 16'hBEEF;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (ser[k] !== 1'b1 || ocu[k] !== 1'b0 || prt[k] !== 1'b0 || st[k] !== 3'd0) begin
                errors += 4;
                $display("FAIL reset inst%0d: got line=%b ocupado=%b pronto=%b state=%0d expected 1 0 0 0",
                         k, ser[k], ocu[k], prt[k], st[k]);
            end
        end
        partida = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_basic;
        start_word(16'hA53C);
        run_word(16'hA53C, 0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_parity;
        start_word(16'h0107);
        run_word(16'h0107, 0, 0, 1'b0, 16'h0);
        start_word(16'h8000);
        run_word(16'h8000, 0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_busy;
        start_word(16'hA53C);
        run_word(16'hA53C, 20, 0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid;
        logic [15:0] w;
        w = 16'($urandom);
        start_word(w);
        run_word(w, 0, 30, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks += 2;
            if (prt[0] !== 1'b0 || prt[1] !== 1'b0) begin
                errors += 2;
                $display("FAIL reset_no_pronto cycle %0d: got %b%b expected 00", i, prt[0], prt[1]);
            end
        end
        start_word(16'h1234);
        run_word(16'h1234, 0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_random;
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            start_word(w);
            run_word(w, 0, 0, 1'b0, 16'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w1, w2;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        @(posedge clock); #1;
        partida = 1'b1;
        dados   = w1;
        @(posedge clock); #1;
        run_word(w1, 0, 0, 1'b1, w2);
        @(posedge clock); #1;
        partida = 1'b0;
        dados   = 16'($urandom);
        run_word(w2, 0, 0, 1'b0, 16'h0);
    endtask

    initial begin
        partida = 1'b0;
        dados   = '0;
        reset   = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
